// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide, MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a one-cycle combinational multiply.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             md_clk,
  input  logic             md_rst,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] md_rs,
  input  logic [WIDTH-1:0] md_rt,
  input  logic             md_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] md_hi,
  output logic [WIDTH-1:0] md_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

  typedef struct packed {
    logic div;
    logic neg_q;
    logic neg_r;
    logic dz;
  } op_t;

  state_t             r_state, w_next;
  op_t                r_op, w_op_new;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_opnd;
  logic [CW-1:0]      r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi, r_lo;

  // ---- request decode ----
  logic               w_is_arith, w_is_div, w_is_signed, w_fast_mul;
  logic               w_sa, w_sb;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [2*WIDTH-1:0] w_mul_init;

  assign w_is_arith  = ~md_op[2];
  assign w_is_div    = md_op[1];
  assign w_is_signed = ~md_op[0];
  assign w_sa        = w_is_signed & md_rs[WIDTH-1];
  assign w_sb        = w_is_signed & md_rt[WIDTH-1];
  assign w_abs_a     = w_sa ? -md_rs : md_rs;
  assign w_abs_b     = w_sb ? -md_rt : md_rt;

`ifdef MULDIV_FAST_MUL_EN
  assign w_fast_mul = ~w_is_div;
  assign w_mul_init = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
`else
  assign w_fast_mul = 1'b0;
  assign w_mul_init = {{WIDTH{1'b0}}, w_abs_b};
`endif

  always_comb begin
    w_op_new.div   = w_is_div;
    w_op_new.neg_q = w_sa ^ w_sb;
    w_op_new.neg_r = w_sa;
    w_op_new.dz    = w_is_div & (md_rt == '0);
  end

  // ---- FSM: state register ----
  always_ff @(posedge md_clk or posedge md_rst) begin
    if (md_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_next = r_state;
    if (md_flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (md_start && w_is_arith) w_next = w_fast_mul ? S_FINISH : S_CALC;
        S_CALC:   if (r_cnt == CW'(WIDTH-1)) w_next = S_FINISH;
        S_FINISH: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // ---- FSM: control outputs ----
  logic w_load, w_step, w_write, w_mthi, w_mtlo;

  always_comb begin
    w_load  = 1'b0;
    w_mthi  = 1'b0;
    w_mtlo  = 1'b0;
    w_step  = 1'b0;
    w_write = 1'b0;
    if (!md_flush) begin
      case (r_state)
        S_IDLE: if (md_start) begin
          w_load = w_is_arith;
          w_mthi = (md_op == 3'b100);
          w_mtlo = (md_op == 3'b101);
        end
        S_CALC:   w_step  = 1'b1;
        S_FINISH: w_write = 1'b1;
        default:  ;
      endcase
    end
  end

  // ---- iteration datapath (HI half = partial product / remainder) ----
  logic [WIDTH-1:0]   w_mul_add, w_div_sub, w_div_rem;
  logic [WIDTH:0]     w_mul_sum, w_div_shift;
  logic               w_div_ok;
  logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt;

  assign w_mul_add   = r_prod[0] ? r_opnd : '0;
  assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, w_mul_add};
  assign w_mul_nxt   = {w_mul_sum, r_prod[WIDTH-1:1]};

  assign w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;
  assign w_div_rem   = w_div_ok ? w_div_sub : w_div_shift[WIDTH-1:0];
  assign w_div_nxt   = {w_div_rem, r_prod[WIDTH-2:0], w_div_ok};

  // ---- sign correction and result mapping ----
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo, w_rem, w_res_hi, w_res_lo;

  assign w_prod_s = r_op.neg_q ? -r_prod : r_prod;
  assign w_quo    = r_prod[WIDTH-1:0];
  assign w_rem    = r_prod[2*WIDTH-1:WIDTH];

  // Divide by zero leaves |rs| in the remainder; restoring its sign yields rs unchanged.
  always_comb begin
    if (r_op.div) begin
      w_res_lo = r_op.dz ? '1 : (r_op.neg_q ? -w_quo : w_quo);
      w_res_hi = r_op.neg_r ? -w_rem : w_rem;
    end else begin
      w_res_lo = w_prod_s[WIDTH-1:0];
      w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge md_clk or posedge md_rst) begin
    if (md_rst) begin
      r_prod <= '0;
      r_opnd <= '0;
      r_op   <= '0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_prod <= w_is_div ? {{WIDTH{1'b0}}, w_abs_a} : w_mul_init;
      r_opnd <= w_is_div ? w_abs_b : w_abs_a;
      r_op   <= w_op_new;
      r_cnt  <= '0;
    end else if (w_step) begin
      r_prod <= r_op.div ? w_div_nxt : w_mul_nxt;
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge md_clk or posedge md_rst) begin
    if (md_rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_write;
      if (w_write) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else begin
        if (w_mthi) r_hi <= md_rs;
        if (w_mtlo) r_lo <= md_rs;
      end
    end
  end

  assign md_busy = (r_state != S_IDLE);
  assign md_done = r_done;
  assign md_hi   = r_hi;
  assign md_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic results, latency, MT/no-op, ignore-while-busy, flush, async reset.
module tb_muldiv_unit;
  localparam int W = 32;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
  localparam logic [2:0] LONG_OP = 3'b011;
  localparam logic [W-1:0] LONG_RS = 32'd30, LONG_RT = 32'd1;
`else
  localparam int MUL_LAT = 33;
  localparam logic [2:0] LONG_OP = 3'b000;
  localparam logic [W-1:0] LONG_RS = 32'd5, LONG_RT = 32'd6;
`endif

  logic         md_clk = 1'b0, md_rst = 1'b1, md_start = 1'b0, md_flush = 1'b0;
  logic [2:0]   md_op = 3'b0;
  logic [W-1:0] md_rs = '0, md_rt = '0;
  logic         md_busy, md_done;
  logic [W-1:0] md_hi, md_lo;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .md_clk(md_clk), .md_rst(md_rst), .md_start(md_start), .md_op(md_op),
    .md_rs(md_rs), .md_rt(md_rt), .md_flush(md_flush),
    .md_busy(md_busy), .md_done(md_done), .md_hi(md_hi), .md_lo(md_lo)
  );

  always #5 md_clk = ~md_clk;

  // Returns at the falling edge right after the accepting edge E0.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    @(negedge md_clk);
    md_start = 1'b1; md_op = op; md_rs = rs; md_rt = rt;
    @(negedge md_clk);
    md_start = 1'b0;
  endtask

  // n = edges after E0 until md_done is visible; nb = sampled busy cycles before that.
  task automatic wait_done(output int n, output int nb, output bit seen);
    n = 0; nb = 0;
    while (!md_done && n < 80) begin
      if (md_busy) nb++;
      @(negedge md_clk);
      n++;
    end
    seen = md_done;
  endtask

  task automatic test_reset;
    #1;
    total++; if ({md_busy, md_done, md_hi, md_lo} !== '0) begin bad++; $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h want all 0", md_busy, md_done, md_hi, md_lo); end
    @(negedge md_clk); md_rst = 1'b0;
    @(negedge md_clk);
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %b want 0", md_busy); end
  endtask

  task automatic test_mult;
    int n, nb; bit seen;
    issue(3'b000, 32'hFFFFFFFD, 32'd7);
    wait_done(n, nb, seen);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL mult_timeout: done not seen after %0d edges", n); end
    total++; if (n !== MUL_LAT) begin bad++; $display("FAIL mult_latency: got %0d want %0d", n, MUL_LAT); end
    total++; if (nb !== MUL_LAT) begin bad++; $display("FAIL mult_busy_cycles: got %0d want %0d", nb, MUL_LAT); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL mult_busy_at_done: got %b want 0", md_busy); end
    total++; if (md_hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", md_hi); end
    total++; if (md_lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_lo: got %h want ffffffeb", md_lo); end
    @(negedge md_clk);
    total++; if (md_done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse: got %b want 0", md_done); end
    issue(3'b000, 32'h80000000, 32'h80000000);
    wait_done(n, nb, seen);
    total++; if ({md_hi, md_lo} !== 64'h40000000_00000000) begin bad++; $display("FAIL mult_minint: got %h%h want 4000000000000000", md_hi, md_lo); end
  endtask

  task automatic test_multu;
    int n, nb; bit seen;
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n, nb, seen);
    total++; if (n !== MUL_LAT) begin bad++; $display("FAIL multu_latency: got %0d want %0d", n, MUL_LAT); end
    total++; if ({md_hi, md_lo} !== 64'hFFFFFFFE_00000001) begin bad++; $display("FAIL multu_result: got %h%h want fffffffe00000001", md_hi, md_lo); end
  endtask

  task automatic test_div;
    int n, nb; bit seen;
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    wait_done(n, nb, seen);
    total++; if (n !== 33) begin bad++; $display("FAIL div_latency: got %0d want 33", n); end
    total++; if (md_lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_neg_lo: got %h want fffffffd", md_lo); end
    total++; if (md_hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_neg_hi: got %h want ffffffff", md_hi); end
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n, nb, seen);
    total++; if ({md_hi, md_lo} !== 64'h00000000_80000000) begin bad++; $display("FAIL div_overflow: got hi=%h lo=%h want hi=0 lo=80000000", md_hi, md_lo); end
    issue(3'b010, 32'd7, 32'hFFFFFFFE);
    wait_done(n, nb, seen);
    total++; if ({md_hi, md_lo} !== 64'h00000001_FFFFFFFD) begin bad++; $display("FAIL div_negdivisor: got hi=%h lo=%h want hi=1 lo=fffffffd", md_hi, md_lo); end
    issue(3'b011, 32'd100, 32'd7);
    wait_done(n, nb, seen);
    total++; if ({md_hi, md_lo} !== 64'h00000002_0000000E) begin bad++; $display("FAIL divu_basic: got hi=%h lo=%h want hi=2 lo=e", md_hi, md_lo); end
  endtask

  task automatic test_divu_zero;
    int n, nb; bit seen;
    issue(3'b011, 32'h12345678, 32'd0);
    wait_done(n, nb, seen);
    total++; if (n !== 33) begin bad++; $display("FAIL divz_latency: got %0d want 33", n); end
    total++; if ({md_hi, md_lo} !== 64'h12345678_FFFFFFFF) begin bad++; $display("FAIL divz_result: got hi=%h lo=%h want hi=12345678 lo=ffffffff", md_hi, md_lo); end
    issue(3'b010, 32'hFFFFFFF9, 32'd0);
    wait_done(n, nb, seen);
    total++; if ({md_hi, md_lo} !== 64'hFFFFFFF9_FFFFFFFF) begin bad++; $display("FAIL divz_signed: got hi=%h lo=%h want hi=fffffff9 lo=ffffffff", md_hi, md_lo); end
  endtask

  task automatic test_noop;
    issue(3'b110, 32'hDEADBEEF, 32'd1);
    total++; if ({md_busy, md_done, md_hi, md_lo} !== {2'b00, 64'hFFFFFFF9_FFFFFFFF}) begin bad++; $display("FAIL noop110: got busy=%b done=%b hi=%h lo=%h", md_busy, md_done, md_hi, md_lo); end
    issue(3'b111, 32'hDEADBEEF, 32'd1);
    total++; if ({md_busy, md_done, md_hi, md_lo} !== {2'b00, 64'hFFFFFFF9_FFFFFFFF}) begin bad++; $display("FAIL noop111: got busy=%b done=%b hi=%h lo=%h", md_busy, md_done, md_hi, md_lo); end
  endtask

  task automatic test_mt_ignore;
    int n; bit seen_done;
    issue(3'b100, 32'hAAAA0000, 32'd0);
    total++; if ({md_busy, md_done, md_hi} !== {2'b00, 32'hAAAA0000}) begin bad++; $display("FAIL mthi: got busy=%b done=%b hi=%h want 0 0 aaaa0000", md_busy, md_done, md_hi); end
    issue(3'b101, 32'h00000055, 32'd0);
    total++; if (md_lo !== 32'h00000055) begin bad++; $display("FAIL mtlo: got %h want 55", md_lo); end
    issue(LONG_OP, LONG_RS, LONG_RT);
    n = 0;
    while (!md_done && n < 80) begin
      if (n == 9)  begin md_start = 1'b1; md_op = 3'b101; md_rs = 32'h1; end
      if (n == 10) begin md_op = LONG_OP; md_rs = 32'd7; md_rt = 32'd3; end
      if (n == 11) md_start = 1'b0;
      if (n == 20) begin
        total++; if ({md_hi, md_lo} !== 64'hAAAA0000_00000055) begin bad++; $display("FAIL busy_hilo_hold: got hi=%h lo=%h want aaaa0000 55", md_hi, md_lo); end
      end
      @(negedge md_clk);
      n++;
    end
    seen_done = md_done;
    total++; if (seen_done !== 1'b1 || n !== 33) begin bad++; $display("FAIL ignore_latency: done=%b edges=%0d want 1 33", seen_done, n); end
    total++; if ({md_hi, md_lo} !== 64'h00000000_0000001E) begin bad++; $display("FAIL ignore_result: got hi=%h lo=%h want 0 1e", md_hi, md_lo); end
    @(negedge md_clk);
    total++; if ({md_busy, md_done} !== 2'b00) begin bad++; $display("FAIL ignore_no_second: got busy=%b done=%b want 0 0", md_busy, md_done); end
  endtask

  task automatic test_back_to_back;
    int n, nb; bit seen;
    issue(3'b011, 32'd100, 32'd7);
    wait_done(n, nb, seen);
    md_start = 1'b1; md_op = 3'b001; md_rs = 32'h00010000; md_rt = 32'h00010000;
    @(negedge md_clk);
    md_start = 1'b0;
    total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy=%b want 1", md_busy); end
    wait_done(n, nb, seen);
    total++; if ({md_hi, md_lo} !== 64'h00000001_00000000) begin bad++; $display("FAIL b2b_result: got hi=%h lo=%h want 1 0", md_hi, md_lo); end
  endtask

  task automatic test_flush;
    bit seen_done;
    issue(3'b100, 32'h11111111, 32'd0);
    issue(3'b101, 32'h22222222, 32'd0);
    issue(3'b010, 32'd100, 32'd7);
    repeat (14) @(negedge md_clk);
    md_flush = 1'b1;
    @(negedge md_clk);
    md_flush = 1'b0;
    total++; if ({md_busy, md_done} !== 2'b00) begin bad++; $display("FAIL flush_idle: got busy=%b done=%b want 0 0", md_busy, md_done); end
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge md_clk);
      if (md_done || md_busy) seen_done = 1'b1;
    end
    total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL flush_no_done: got activity=%b want 0", seen_done); end
    total++; if ({md_hi, md_lo} !== 64'h11111111_22222222) begin bad++; $display("FAIL flush_hilo: got hi=%h lo=%h want 11111111 22222222", md_hi, md_lo); end
  endtask

  task automatic test_async_reset;
    int n, nb; bit seen;
    issue(3'b000, 32'd3, 32'd5);
    repeat (5) @(negedge md_clk);
    #2 md_rst = 1'b1;
    #1;
    total++; if ({md_busy, md_done, md_hi, md_lo} !== '0) begin bad++; $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h want all 0", md_busy, md_done, md_hi, md_lo); end
    @(negedge md_clk);
    md_rst = 1'b0;
    issue(3'b011, 32'd100, 32'd7);
    wait_done(n, nb, seen);
    total++; if ({md_hi, md_lo} !== 64'h00000002_0000000E) begin bad++; $display("FAIL post_reset_div: got hi=%h lo=%h want 2 e", md_hi, md_lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divu_zero();
    test_noop();
    test_mt_ignore();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
